dp_pipe: RTL
============

Name: dp_pipe

Overview:
- Next-generation datapath: input select mux, multi-port register file, extended ALU, and an output gate.
- Parametrised in word width and register count.
- The ALU path is pipelined: operand registers feed a registered result with valid and status flags.
- Register-file write-through bypass is included.
- Sits under the control FSM; all select, enable and address fields are driven cycle by cycle by the controller.

Parameters:
- WIDTH, 3, datapath word width in bits (>=2).
- DEPTH, 4, number of register-file entries (power of two, >=2).
- AW, $clog2(DEPTH), register address width (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in1  input  WIDTH  external operand 1.
- in2  input  WIDTH  external operand 2.
- s1  input  2  write-data select: 0=in1, 1=in2, 2=zero, 3=res_q.
- we  input  1  register-file write enable.
- wa  input  AW  write address.
- rea  input  1  read-port A enable.
- raa  input  AW  read-port A address.
- reb  input  1  read-port B enable.
- rab  input  AW  read-port B address.
- go  input  1  issue: capture operands and op this cycle.
- c  input  3  ALU opcode, captured with go.
- s2  input  1  output gate: 0=result, 1=force zero.
- out  output  WIDTH  gated registered result.
- out_valid  output  1  res_q holds a result not yet superseded since reset.
- zf  output  1  zero flag of res_q.
- cf  output  1  carry/borrow/shift-out flag of res_q.

Behaviour:
- Reset (rst_n low, async): all RF entries, op_a, op_b, op_c, op_v, res_q, zf, cf and out_valid go to 0. out=0. Reset mid-pipeline discards in-flight ops.
- Write data din = mux(s1). On a clock edge with we=1: RF[wa] <= din. s1=3 writes the res_q value present before the edge.
- Read port A: rd_a = rea ? RF[raa] : 0. Port B is identical, using reb/rab.
- Bypass: if we=1 and wa equals a port's address with that port enabled, the port returns din in the same cycle (write-through). Both ports may bypass simultaneously.
- Stage 1, on an edge with go=1: op_a<=rd_a, op_b<=rd_b, op_c<=c, op_v<=1. With go=0: op_v<=0 and operands hold.
- Stage 2, on an edge with op_v=1: res_q<=alu(op_a,op_b,op_c), zf and cf are updated, out_valid<=1. With op_v=0, res_q, zf, cf and out_valid hold.
- Latency: go at edge N gives res_q at edge N+1. Back-to-back go is allowed, at one result per cycle.
- ALU arithmetic is modulo 2^WIDTH. cf is defined per opcode:
  - 0 ADD: cf = carry out.
  - 1 SUB (a-b): cf = borrow, 1 when a<b unsigned.
  - 2 AND: cf = 0.
  - 3 OR: cf = 0.
  - 4 XOR: cf = 0.
  - 5 SHL by 1: cf = a[WIDTH-1]; LSB filled with 0.
  - 6 SHR by 1 (logical): cf = a[0].
  - 7 PASS a: cf = 0.
- zf = (result == 0). Flags always describe res_q.
- out = s2 ? 0 : res_q. s2 is combinational and does not affect state.
- Write and go in the same cycle: the operands captured are the bypassed (new) values.
- Address wrap: addresses are AW bits wide, so out-of-range addresses cannot occur. Any AW-bit address is legal.
- Self-feedback: s1=3 with we=1 and go=1 in the same cycle is legal. The RF gets the old res_q while res_q updates from the previous op.
- No X propagation: disabled reads yield 0, never the stale port value.

Test Plan:
- Reset: load RF via s1=0, then pulse rst_n low between edges -> out=0, out_valid=0, zf=0, cf=0 immediately; all RF entries read 0.
- ADD with defaults: RF[1]=5, RF[2]=6 (via in1/in2), go with raa=1, rab=2, c=0 -> next edge res_q=3 (11 mod 8), cf=1, zf=0, out=3, out_valid=1; s2=1 -> out=0.
- SUB borrow/zero: RF[0]=2, RF[3]=2, c=1 -> res_q=0, zf=1, cf=0. Then RF[3]=4, c=1 -> res_q=6, cf=1.
- Bypass: same cycle we=1, wa=2, s1=1, in2=7, rea=1, raa=2, reb=0, go=1, c=7 -> res_q=7. Disabled port B contributes 0 (c=0 gives 7).
- Pipeline/feedback at WIDTH=8, DEPTH=8: go on consecutive cycles (ADD 100+100, SHL 0x81, SHR 0x01) -> results 200/cf0, 0x02/cf1, 0x00/zf1/cf1 on successive edges. Then s1=3, we=1, wa=7 -> RF[7]=0x00.
- Hold/reset mid-op: go once, then go=0 for 3 cycles -> res_q, flags and out_valid stable. Assert rst_n the cycle after go -> op dropped, out_valid stays 0.

Source files
------------

// File: rtl/dp_pipe.sv
// Datapath: write-data mux, register file with write-through bypass on two read
// ports, a two-stage ALU pipeline (operand registers, then result with flags), and a zero gate.
module dp_pipe #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       s1,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic             rea,
  input  logic [AW-1:0]    raa,
  input  logic             reb,
  input  logic [AW-1:0]    rab,
  input  logic             go,
  input  logic [2:0]       c,
  input  logic             s2,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             zf,
  output logic             cf
);

  logic [WIDTH-1:0] rf_q [DEPTH];
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic [2:0]       op_c_q;
  logic             op_v_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zf_q, cf_q, cf_d, vld_q;
  logic [WIDTH:0]   ext;

  always_comb begin
    din = '0;
    case (s1)
      2'd0:    din = in1;
      2'd1:    din = in2;
      2'd2:    din = '0;
      default: din = res_q;
    endcase
  end

  // Disabled ports read as zero; an enabled port whose address is being written sees din.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (rea) rd_a = (we && (wa == raa)) ? din : rf_q[raa];
    if (reb) rd_b = (we && (wa == rab)) ? din : rf_q[rab];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else if (we) begin
      rf_q[wa] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q <= '0;
      op_b_q <= '0;
      op_c_q <= '0;
      op_v_q <= 1'b0;
    end else begin
      op_v_q <= go;
      if (go) begin
        op_a_q <= rd_a;
        op_b_q <= rd_b;
        op_c_q <= c;
      end
    end
  end

  always_comb begin
    res_d = '0;
    cf_d  = 1'b0;
    ext   = '0;
    case (op_c_q)
      3'd0: begin
        ext   = {1'b0, op_a_q} + {1'b0, op_b_q};
        res_d = ext[WIDTH-1:0];
        cf_d  = ext[WIDTH];
      end
      3'd1: begin
        // The extra MSB of the extended difference is the borrow.
        ext   = {1'b0, op_a_q} - {1'b0, op_b_q};
        res_d = ext[WIDTH-1:0];
        cf_d  = ext[WIDTH];
      end
      3'd2: res_d = op_a_q & op_b_q;
      3'd3: res_d = op_a_q | op_b_q;
      3'd4: res_d = op_a_q ^ op_b_q;
      3'd5: begin
        res_d = {op_a_q[WIDTH-2:0], 1'b0};
        cf_d  = op_a_q[WIDTH-1];
      end
      3'd6: begin
        res_d = {1'b0, op_a_q[WIDTH-1:1]};
        cf_d  = op_a_q[0];
      end
      default: res_d = op_a_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      zf_q  <= 1'b0;
      cf_q  <= 1'b0;
      vld_q <= 1'b0;
    end else if (op_v_q) begin
      res_q <= res_d;
      zf_q  <= (res_d == '0);
      cf_q  <= cf_d;
      vld_q <= 1'b1;
    end
  end

  assign out       = s2 ? '0 : res_q;
  assign out_valid = vld_q;
  assign zf        = zf_q;
  assign cf        = cf_q;

endmodule
